fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch front end: the initiator side of the instruction memory interface.
- Owns the PC register, drives the fetch address to the instruction memory and captures the returned word into the IF/ID pipeline register.
- Handles hazard freeze, cache-miss stall, and branch redirect/flush from EXE.
- Exposes fetch and stall counters for measuring cache speed-up.

Parameters:
RESET_VECTOR, 32'd0, PC value loaded on reset
PC_STEP, 32'd4, sequential fetch increment in bytes

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
freeze  input  1  hazard unit stall; hold PC and IF/ID
mem_stall  input  1  data-cache miss stall; holds the whole front end
branch_taken  input  1  EXE resolved taken branch
branch_address  input  32  branch target byte address from EXE
instruction  input  32  word returned combinationally by instruction memory for pc_out
pc_out  output  32  fetch address to instruction memory (= PC register)
if_id_pc  output  32  registered PC+PC_STEP of the captured instruction
if_id_instruction  output  32  registered instruction word
if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
fetch_count  output  32  number of instructions captured valid into IF/ID
stall_count  output  32  cycles with freeze or mem_stall asserted

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - PC=RESET_VECTOR; if_id_pc=0; if_id_instruction=0; if_id_valid=0; fetch_count=0; stall_count=0.
  - Deassertion takes effect at the next rising edge. Reset mid-stall or mid-branch discards all state.
- pc_out is the PC register, directly with no logic. PC[1:0] is always 0; branch_address[1:0] is ignored (forced to 0).
- Fetch latency: instruction is valid in the same cycle as pc_out. The word addressed by PC appears on if_id_instruction one cycle after PC is presented.
- Per rising edge, priority is highest first:
  1. mem_stall=1: PC, IF/ID and fetch_count hold; branch_taken ignored (EXE is also held, so the branch is re-presented later); stall_count+1.
  2. branch_taken=1: PC<=branch_address&~3; IF/ID flushed (if_id_instruction<=0, if_id_pc<=0, if_id_valid<=0); freeze ignored; fetch_count holds.
  3. freeze=1: PC and IF/ID hold; stall_count+1.
  4. otherwise: PC<=PC+PC_STEP; if_id_instruction<=instruction; if_id_pc<=PC+PC_STEP; if_id_valid<=1; fetch_count+1.
- freeze and mem_stall both set: count one stall cycle, not two.
- Arithmetic:
  - PC+PC_STEP is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0 with no error.
  - Both counters saturate at 32'hFFFFFFFF.
- Single-cycle flush only. The instruction already in IF/ID when the branch resolves is the ID-stage slot and is killed by this flush. Any further flush belongs to downstream stages.
- No combinational path from any input to pc_out.

Test Plan:
- Reset then 4 free-running cycles:
  - pc_out sequence 0,4,8,12,16.
  - At cycle 1: if_id_instruction=32'hE3A00B01, if_id_pc=4, if_id_valid=1.
  - fetch_count=4.
- freeze=1 for 3 cycles at PC=8: pc_out stays 8, IF/ID stays {pc 8, instr at 4}, stall_count=3. After release, next capture is word at 8 with if_id_pc=12.
- branch_taken=1 with branch_address=32'h0000004E at PC=20:
  - Next cycle pc_out=32'h4C, if_id_valid=0, if_id_instruction=0.
  - Following cycle captures word at 0x4C with if_id_pc=0x50.
- mem_stall=1 and branch_taken=1 together for 2 cycles, then mem_stall=0 with branch held: PC frozen both cycles, stall_count+=2, then redirect occurs.
- freeze=1 and branch_taken=1 same cycle: redirect wins, IF/ID flushed, stall_count unchanged.
- Assert rst low asynchronously mid-freeze at PC=0x40 with counters nonzero: outputs reach reset values before the next edge. Set PC to 32'hFFFFFFFC via a branch, run one cycle: pc_out wraps to 0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction memory bus between the fetch stage (master) and the
// instruction memory (slave). The memory answers combinationally with the
// word addressed by pc_out.
interface fetch_stage_if;
    logic [31:0] pc_out;
    logic [31:0] instruction;

    modport master (
        output pc_out,
        input  instruction
    );

    modport slave (
        input  pc_out,
        output instruction
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end. Owns the PC, presents it to instruction
// memory, and captures the returned word into the IF/ID pipeline register.
// A data-cache stall holds everything. A taken branch redirects the PC and
// flushes IF/ID. A hazard freeze holds PC and IF/ID.
// The fetch and stall counters saturate so long runs never wrap back to
// small values.
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'd0,
    parameter logic [31:0] PC_STEP      = 32'd4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          mem_stall,
    input  logic          branch_taken,
    input  logic [31:0]   branch_address,
    fetch_stage_if.master imem,
    output logic [31:0]   if_id_pc,
    output logic [31:0]   if_id_instruction,
    output logic          if_id_valid,
    output logic [31:0]   fetch_count,
    output logic [31:0]   stall_count
);

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] pc;
    logic [31:0] pc_plus_step;
    logic [31:0] branch_target;

    assign imem.pc_out = pc;

    // Sequential successor and word-aligned branch target; adds wrap modulo 2^32
    always_comb begin
        pc_plus_step  = (pc + PC_STEP) & WORD_MASK;
        branch_target = branch_address & WORD_MASK;
    end

    // PC, IF/ID and counters; mem_stall beats branch beats freeze beats fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc                <= RESET_VECTOR & WORD_MASK;
            if_id_pc          <= 32'd0;
            if_id_instruction <= 32'd0;
            if_id_valid       <= 1'b0;
            fetch_count       <= 32'd0;
            stall_count       <= 32'd0;
        end else if (mem_stall) begin
            if (stall_count != COUNT_MAX) begin
                stall_count <= stall_count + 32'd1;
            end
        end else if (branch_taken) begin
            pc                <= branch_target;
            if_id_pc          <= 32'd0;
            if_id_instruction <= 32'd0;
            if_id_valid       <= 1'b0;
        end else if (freeze) begin
            if (stall_count != COUNT_MAX) begin
                stall_count <= stall_count + 32'd1;
            end
        end else begin
            pc                <= pc_plus_step;
            if_id_pc          <= pc_plus_step;
            if_id_instruction <= imem.instruction;
            if_id_valid       <= 1'b1;
            if (fetch_count != COUNT_MAX) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. A small instruction memory returns
// 32'hE3A00B01 at address 0 and {16'hA5A5, addr[15:0]} everywhere else.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        mem_stall;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    int tests_run;
    int tests_failed;

    fetch_stage_if imem ();

    fetch_stage #(
        .RESET_VECTOR (32'd0),
        .PC_STEP      (32'd4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .freeze            (freeze),
        .mem_stall         (mem_stall),
        .branch_taken      (branch_taken),
        .branch_address    (branch_address),
        .imem              (imem.master),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid),
        .fetch_count       (fetch_count),
        .stall_count       (stall_count)
    );

    // Combinational instruction memory model
    always_comb begin
        if (imem.pc_out == 32'd0) begin
            imem.instruction = 32'hE3A00B01;
        end else begin
            imem.instruction = {16'hA5A5, imem.pc_out[15:0]};
        end
    end

    // 10-unit clock, first rising edge at time 5
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc,
                               input logic [31:0] ipc, input logic [31:0] instr,
                               input logic valid);
        check_output({tag, " pc_out"}, imem.pc_out, pc);
        check_output({tag, " if_id_pc"}, if_id_pc, ipc);
        check_output({tag, " if_id_instruction"}, if_id_instruction, instr);
        check_output({tag, " if_id_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    task automatic check_counts(input string tag, input logic [31:0] fetches,
                                input logic [31:0] stalls);
        check_output({tag, " fetch_count"}, fetch_count, fetches);
        check_output({tag, " stall_count"}, stall_count, stalls);
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b0;
        freeze         = 1'b0;
        mem_stall      = 1'b0;
        branch_taken   = 1'b0;
        branch_address = 32'd0;

        // Reset values before any clock edge
        #3;
        check_state("reset", 32'd0, 32'd0, 32'd0, 1'b0);
        check_counts("reset", 32'd0, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("after release pc_out", imem.pc_out, 32'd0);

        // Free running: capture word at 0, then word at 4
        tick();
        check_state("run1", 32'd4, 32'd4, 32'hE3A00B01, 1'b1);
        tick();
        check_state("run2", 32'd8, 32'd8, 32'hA5A50004, 1'b1);

        // Freeze three cycles at PC=8
        freeze = 1'b1;
        tick();
        tick();
        tick();
        check_state("freeze3", 32'd8, 32'd8, 32'hA5A50004, 1'b1);
        check_counts("freeze3", 32'd2, 32'd3);
        freeze = 1'b0;
        tick();
        check_state("unfreeze", 32'd12, 32'd12, 32'hA5A50008, 1'b1);
        tick();
        check_output("run pc 16", imem.pc_out, 32'd16);
        check_counts("run pc 16", 32'd4, 32'd3);
        tick();
        check_output("run pc 20", imem.pc_out, 32'd20);

        // Taken branch to 0x4E (low bits dropped) at PC=20
        branch_taken   = 1'b1;
        branch_address = 32'h0000004E;
        tick();
        check_state("branch", 32'h4C, 32'd0, 32'd0, 1'b0);
        check_counts("branch", 32'd5, 32'd3);
        branch_taken = 1'b0;
        tick();
        check_state("after branch", 32'h50, 32'h50, 32'hA5A5004C, 1'b1);
        check_counts("after branch", 32'd6, 32'd3);

        // mem_stall with branch for two cycles: branch ignored, stalls counted
        mem_stall      = 1'b1;
        branch_taken   = 1'b1;
        branch_address = 32'h00000100;
        tick();
        check_output("mstall1 pc_out", imem.pc_out, 32'h50);
        check_output("mstall1 stall_count", stall_count, 32'd4);
        freeze = 1'b1;
        tick();
        check_state("mstall2", 32'h50, 32'h50, 32'hA5A5004C, 1'b1);
        check_counts("mstall2 both", 32'd6, 32'd5);
        freeze    = 1'b0;
        mem_stall = 1'b0;
        tick();
        check_state("mstall redirect", 32'h100, 32'd0, 32'd0, 1'b0);
        check_counts("mstall redirect", 32'd6, 32'd5);
        branch_taken = 1'b0;
        tick();
        check_state("run 0x104", 32'h104, 32'h104, 32'hA5A50100, 1'b1);

        // freeze and branch together: redirect wins, no stall counted
        freeze         = 1'b1;
        branch_taken   = 1'b1;
        branch_address = 32'h00000040;
        tick();
        check_state("freeze+branch", 32'h40, 32'd0, 32'd0, 1'b0);
        check_counts("freeze+branch", 32'd7, 32'd5);
        branch_taken = 1'b0;
        tick();
        tick();
        check_output("freeze at 0x40 pc_out", imem.pc_out, 32'h40);
        check_counts("freeze at 0x40", 32'd7, 32'd7);

        // Asynchronous reset mid-freeze, checked before the next edge
        rst = 1'b0;
        #1;
        check_state("async reset", 32'd0, 32'd0, 32'd0, 1'b0);
        check_counts("async reset", 32'd0, 32'd0);
        freeze = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Branch to top of memory, then wrap to 0
        branch_taken   = 1'b1;
        branch_address = 32'hFFFFFFFE;
        tick();
        check_output("branch top pc_out", imem.pc_out, 32'hFFFFFFFC);
        branch_taken = 1'b0;
        tick();
        check_state("wrap", 32'd0, 32'd0, 32'hA5A5FFFC, 1'b1);
        check_counts("wrap", 32'd1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
